multi_debouncer: RTL and testbench
==================================

MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent input channels (1..32).
REQ-002 Parameter STABLE_MS, default 8, consecutive clk_1KHz samples needed to accept a level change (2..255).
REQ-003 Parameter LONG_MS, default 1000, hold time in ms before long-press detection (must exceed STABLE_MS; 0 disables long-press detection).
REQ-004 Parameter REPEAT_MS, default 0, auto-repeat period in ms after long press (0 disables auto-repeat).
REQ-005 Parameter ACTIVE_LOW, default 1, 1 inverts raw inputs so that "pressed" is internal logic 1.
REQ-006 clk_1KHz  input  1  sample clock, all logic on its rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset, synchronously deasserted by the system.
REQ-008 noisy_in  input  NUM_CH  raw, asynchronous switch/button levels.
REQ-009 debounced  output  NUM_CH  filtered level per channel, 1 = pressed.
REQ-010 press_pulse  output  NUM_CH  one-cycle pulse on accepted 0->1 transition.
REQ-011 release_pulse  output  NUM_CH  one-cycle pulse on accepted 1->0 transition.
REQ-012 long_pulse  output  NUM_CH  one-cycle pulse when hold reaches LONG_MS.
REQ-013 repeat_pulse  output  NUM_CH  one-cycle pulse every REPEAT_MS while held after long press.
REQ-014 long_active  output  NUM_CH  level, high from long_pulse until release.

Function
REQ-015 Each channel shall pass its input (after ACTIVE_LOW inversion) through a 2-flop synchroniser before filtering.
REQ-016 Stable counter: clears whenever the synchronised sample equals debounced, increments otherwise.
REQ-017 When the counter is STABLE_MS-1 and the sample still differs, debounced shall toggle next edge and the counter shall clear.
REQ-018 Latency: debounced changes exactly 2 + STABLE_MS clk_1KHz edges after a clean raw input step.
REQ-019 Any glitch shorter than STABLE_MS samples shall produce no change on any output.
REQ-020 press_pulse/release_pulse shall assert in the same cycle debounced changes, for exactly one cycle.
REQ-021 Per-channel FSM states: RELEASED, PRESSED, LONG; reset state RELEASED.
REQ-022 RELEASED->PRESSED on debounced rise, hold counter cleared.
REQ-023 PRESSED: hold counter increments each cycle; at count LONG_MS-1 go to LONG, long_pulse for one cycle, long_active set.
REQ-024 LONG: if REPEAT_MS>0, repeat_pulse every REPEAT_MS cycles, first one REPEAT_MS cycles after long_pulse; repeat counter wraps to 0 after each pulse.
REQ-025 PRESSED or LONG -> RELEASED on debounced fall; long_active clears the same cycle release_pulse asserts; no long/repeat pulse in that cycle.
REQ-026 Hold counter shall saturate and never wrap while in LONG; holds of any length shall produce exactly one long_pulse.
REQ-027 LONG_MS=0: FSM never enters LONG; long_pulse, repeat_pulse, long_active held 0.
REQ-028 Channels are fully independent; simultaneous events on several channels produce simultaneous pulses.
REQ-029 Counter widths derive from parameters via $clog2, minimum 1 bit; no truncation for legal parameter ranges.

Reset
REQ-030 On reset_n low, all synchroniser flops, counters, FSMs and outputs shall clear immediately to inactive (0) regardless of clk_1KHz.
REQ-031 An input held pressed through reset release shall be accepted as a normal press after 2 + STABLE_MS edges (press_pulse asserted).
REQ-032 Reset mid-hold shall discard hold state; no release_pulse is generated by reset.

Structure
REQ-033 Package debounce_pkg shall hold the FSM state enum (RELEASED, PRESSED, LONG) and a counter-width helper function.
REQ-034 Sub-module debounce_channel shall implement one channel (synchroniser, filter, FSM); multi_debouncer instantiates NUM_CH copies via generate.

Verification
REQ-035 STABLE_MS=8: clean step 0->1 on ch0 -> debounced[0] and press_pulse[0] high at edge 10, pulse width 1.
REQ-036 Glitch of 7 samples high on ch1 -> all ch1 outputs remain 0; 8-sample pulse -> press then release pulses.
REQ-037 LONG_MS=20, REPEAT_MS=5, hold ch2 for 40 ms -> one long_pulse 20 cycles after press_pulse, repeat_pulses every 5 cycles, long_active drops with release_pulse.
REQ-038 Simultaneous press on all 4 channels -> four press_pulse bits in the same cycle.
REQ-039 Assert reset_n low mid-hold in LONG state -> all outputs 0 asynchronously; input still pressed after release -> new press_pulse at edge 10.
REQ-040 ACTIVE_LOW=1, raw input held high from reset -> no pulses ever; driven low 8+ ms -> press_pulse.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel button debouncer.
//   btn_state_e : per-channel press-tracking state (RELEASED, PRESSED, LONG)
//   cnt_width() : bits needed to hold a counter value 0..max_val (min 1 bit)
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    LONG     = 2'd2
  } btn_state_e;

  function automatic int cnt_width(input int max_val);
    if (max_val < 2) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-flop synchroniser, stability filter and
// press/long-press/auto-repeat tracker.
// Ports:
//   clk_1KHz      : sample clock, all state updates on its rising edge
//   reset_n       : asynchronous active-low reset
//   raw_in        : raw level, already oriented so 1 = pressed
//   debounced     : filtered level
//   press_pulse   : one cycle, same cycle debounced rises
//   release_pulse : one cycle, same cycle debounced falls
//   long_pulse    : one cycle when the hold reaches LONG_MS
//   repeat_pulse  : one cycle every REPEAT_MS while in long press
//   long_active   : high from long_pulse until release
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_MS = 8,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 0
) (
  input  logic clk_1KHz,
  input  logic reset_n,
  input  logic raw_in,
  output logic debounced,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic long_active
);

  localparam int SW = cnt_width(STABLE_MS - 1);
  localparam int HW = cnt_width(LONG_MS);
  localparam int RW = cnt_width(REPEAT_MS);
  localparam bit LONG_EN   = (LONG_MS > 0);
  localparam bit REPEAT_EN = (REPEAT_MS > 0);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_MS - 1);
  localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_EN ? LONG_MS - 1 : 0);
  localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_EN ? REPEAT_MS - 1 : 0);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [SW-1:0] stable_cnt_q, stable_cnt_d;
  logic          deb_q, deb_d;
  btn_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          long_act_q, long_act_d;
  logic          rise, fall;

  // The filter toggles on the same edge the FSM sees the change, so the
  // press/release pulses line up with the new debounced level.
  always_comb begin
    sync1_d      = raw_in;
    sync2_d      = sync1_q;
    deb_d        = deb_q;
    stable_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (stable_cnt_q == STABLE_LAST) begin
        deb_d = ~deb_q;
      end else begin
        stable_cnt_d = stable_cnt_q + SW'(1);
      end
    end

    rise = deb_d & ~deb_q;
    fall = ~deb_d & deb_q;

    state_d    = state_q;
    hold_d     = hold_q;
    rep_d      = rep_q;
    press_d    = rise;
    release_d  = fall;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    long_act_d = long_act_q;

    case (state_q)
      RELEASED: begin
        if (rise) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_d = RELEASED;
        end else if (LONG_EN && (hold_q == LONG_LAST)) begin
          state_d    = LONG;
          long_d     = 1'b1;
          long_act_d = 1'b1;
          rep_d      = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      LONG: begin
        // Hold count stays parked here, so an endless hold cannot re-fire.
        if (fall) begin
          state_d    = RELEASED;
          long_act_d = 1'b0;
        end else if (REPEAT_EN) begin
          if (rep_q == REPEAT_LAST) begin
            repeat_d = 1'b1;
            rep_d    = '0;
          end else begin
            rep_d = rep_q + RW'(1);
          end
        end
      end
      default: begin
        state_d    = RELEASED;
        long_act_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_1KHz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_cnt_q <= '0;
      deb_q        <= 1'b0;
      state_q      <= RELEASED;
      hold_q       <= '0;
      rep_q        <= '0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_q       <= 1'b0;
      repeat_q     <= 1'b0;
      long_act_q   <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_cnt_q <= stable_cnt_d;
      deb_q        <= deb_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      rep_q        <= rep_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_q       <= long_d;
      repeat_q     <= repeat_d;
      long_act_q   <= long_act_d;
    end
  end

  assign debounced     = deb_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign long_active   = long_act_q;

endmodule

// File: rtl/multi_debouncer.sv
// NUM_CH independent button debouncers sampled on a 1 kHz clock.
// Ports:
//   clk_1KHz      : sample clock
//   reset_n       : asynchronous active-low reset
//   noisy_in      : raw switch levels (inverted first when ACTIVE_LOW)
//   debounced     : filtered levels, 1 = pressed
//   press_pulse / release_pulse : accepted edge pulses
//   long_pulse / repeat_pulse   : long-press and auto-repeat pulses
//   long_active   : long press in progress
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int STABLE_MS  = 8,
  parameter int LONG_MS    = 1000,
  parameter int REPEAT_MS  = 0,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk_1KHz,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] noisy_in,
  output logic [NUM_CH-1:0] debounced,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] long_pulse,
  output logic [NUM_CH-1:0] repeat_pulse,
  output logic [NUM_CH-1:0] long_active
);

  logic [NUM_CH-1:0] pressed_raw;

  assign pressed_raw = (ACTIVE_LOW != 0) ? ~noisy_in : noisy_in;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_MS(STABLE_MS),
      .LONG_MS  (LONG_MS),
      .REPEAT_MS(REPEAT_MS)
    ) u_ch (
      .clk_1KHz     (clk_1KHz),
      .reset_n      (reset_n),
      .raw_in       (pressed_raw[g]),
      .debounced    (debounced[g]),
      .press_pulse  (press_pulse[g]),
      .release_pulse(release_pulse[g]),
      .long_pulse   (long_pulse[g]),
      .repeat_pulse (repeat_pulse[g]),
      .long_active  (long_active[g])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer with randomized and directed
// button activity compared against a window/hold-time reference model.
module tb_multi_debouncer;

  localparam int NUM_CH     = 4;
  localparam int STABLE_MS  = 8;
  localparam int LONG_MS    = 20;
  localparam int REPEAT_MS  = 5;
  localparam int ACTIVE_LOW = 1;

  logic              clk_1KHz = 1'b0;
  logic              reset_n  = 1'b1;
  logic [NUM_CH-1:0] noisy_in;
  logic [NUM_CH-1:0] debounced, press_pulse, release_pulse;
  logic [NUM_CH-1:0] long_pulse, repeat_pulse, long_active;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  // Reference model state: raw history per channel (bit0 = newest sample),
  // accepted level and ms held since the accepted press.
  logic [15:0]       hist [NUM_CH];
  logic [NUM_CH-1:0] m_deb;
  int                m_held [NUM_CH];
  logic [NUM_CH-1:0] e_deb, e_press, e_rel, e_long, e_rep, e_la;

  multi_debouncer #(
    .NUM_CH    (NUM_CH),
    .STABLE_MS (STABLE_MS),
    .LONG_MS   (LONG_MS),
    .REPEAT_MS (REPEAT_MS),
    .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .clk_1KHz     (clk_1KHz),
    .reset_n      (reset_n),
    .noisy_in     (noisy_in),
    .debounced    (debounced),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .long_active  (long_active)
  );

  always #5 clk_1KHz = ~clk_1KHz;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (edge %0d)", tag,
               observed, expected, edge_cnt);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < NUM_CH; c++) begin
      hist[c]   = '0;
      m_held[c] = 0;
    end
    m_deb = '0;
    e_deb = '0; e_press = '0; e_rel = '0; e_long = '0; e_rep = '0; e_la = '0;
  endtask

  // A level is accepted once the STABLE_MS samples seen through the two-edge
  // synchroniser delay all disagree with the current level.
  task automatic modelEdge(input logic [NUM_CH-1:0] pressed);
    logic [7:0] win;
    logic       tog;
    for (int c = 0; c < NUM_CH; c++) begin
      hist[c] = {hist[c][14:0], pressed[c]};
      win = hist[c][9:2];
      tog = m_deb[c] ? (win == 8'h00) : (win == 8'hFF);
      e_press[c] = tog && !m_deb[c];
      e_rel[c]   = tog && m_deb[c];
      if (tog) m_deb[c] = ~m_deb[c];
      if (!m_deb[c] || tog) m_held[c] = 0;
      else m_held[c]++;
      e_deb[c]  = m_deb[c];
      e_long[c] = m_deb[c] && !tog && (LONG_MS > 0) && (m_held[c] == LONG_MS);
      e_rep[c]  = m_deb[c] && !tog && (LONG_MS > 0) && (REPEAT_MS > 0) &&
                  (m_held[c] > LONG_MS) &&
                  (((m_held[c] - LONG_MS) % REPEAT_MS) == 0);
      e_la[c]   = m_deb[c] && (LONG_MS > 0) && (m_held[c] >= LONG_MS);
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, "_debounced"}, 32'(debounced), 32'(e_deb));
    checkOutput({tag, "_press"}, 32'(press_pulse), 32'(e_press));
    checkOutput({tag, "_release"}, 32'(release_pulse), 32'(e_rel));
    checkOutput({tag, "_long"}, 32'(long_pulse), 32'(e_long));
    checkOutput({tag, "_repeat"}, 32'(repeat_pulse), 32'(e_rep));
    checkOutput({tag, "_long_active"}, 32'(long_active), 32'(e_la));
  endtask

  // One 1 ms sample: drive the pressed pattern, clock it, compare.
  task automatic applyStimulus(input logic [NUM_CH-1:0] pressed);
    noisy_in = (ACTIVE_LOW != 0) ? ~pressed : pressed;
    @(posedge clk_1KHz);
    #1;
    edge_cnt++;
    modelEdge(pressed);
    compareAll("cyc");
  endtask

  // Asserts reset away from any clock edge and checks the outputs clear
  // without a clock, then releases it near a falling edge.
  task automatic applyReset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    compareAll(tag);
    @(posedge clk_1KHz);
    @(posedge clk_1KHz);
    @(negedge clk_1KHz);
    reset_n = 1'b1;
    edge_cnt = 0;
  endtask

  initial begin
    int            press_edge, long_edge, rel_edge, long_cnt, rep_cnt;
    int            press_cnt, rel_cnt;
    logic          la_prev, la_before_rel, la_at_rel;
    logic [NUM_CH-1:0] act;
    logic [NUM_CH-1:0] lvl;
    int            dur [NUM_CH];

    noisy_in = '1;
    modelReset();
    applyReset("rst0");

    // Clean step on ch0: accepted at edge 2 + STABLE_MS, single-cycle pulse.
    for (int i = 0; i < 30; i++) begin
      applyStimulus(4'b0001);
      if (press_pulse[0]) break;
    end
    checkOutput("ch0_press_edge", 32'(edge_cnt), 32'(2 + STABLE_MS));
    applyStimulus(4'b0001);
    checkOutput("ch0_pulse_width", 32'(press_pulse[0]), 32'd0);
    for (int i = 0; i < 12; i++) applyStimulus(4'b0000);

    // Glitch of STABLE_MS-1 samples on ch1 must leave every ch1 output idle.
    act = '0;
    for (int i = 0; i < STABLE_MS - 1; i++) begin
      applyStimulus(4'b0010);
      act[1] = act[1] | debounced[1] | press_pulse[1] | release_pulse[1];
    end
    for (int i = 0; i < 15; i++) begin
      applyStimulus(4'b0000);
      act[1] = act[1] | debounced[1] | press_pulse[1] | release_pulse[1];
    end
    checkOutput("glitch7_quiet", 32'(act), 32'd0);

    // Exactly STABLE_MS samples is accepted, then released.
    press_cnt = 0; rel_cnt = 0;
    for (int i = 0; i < STABLE_MS; i++) begin
      applyStimulus(4'b0010);
      press_cnt += int'(press_pulse[1]);
      rel_cnt += int'(release_pulse[1]);
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'b0000);
      press_cnt += int'(press_pulse[1]);
      rel_cnt += int'(release_pulse[1]);
    end
    checkOutput("pulse8_press_cnt", 32'(press_cnt), 32'd1);
    checkOutput("pulse8_release_cnt", 32'(rel_cnt), 32'd1);

    // 40 ms hold on ch2: press at 10, long at 30, repeats at 35/40/45,
    // release at 50 where the would-be repeat is suppressed.
    applyReset("rst1");
    press_edge = 0; long_edge = 0; rel_edge = 0; long_cnt = 0; rep_cnt = 0;
    la_prev = 1'b0; la_before_rel = 1'b0; la_at_rel = 1'b1;
    for (int i = 0; i < 60; i++) begin
      applyStimulus((i < 40) ? 4'b0100 : 4'b0000);
      if (press_pulse[2]) press_edge = edge_cnt;
      if (long_pulse[2]) begin
        long_cnt++;
        long_edge = edge_cnt;
      end
      rep_cnt += int'(repeat_pulse[2]);
      if (release_pulse[2]) begin
        rel_edge = edge_cnt;
        la_before_rel = la_prev;
        la_at_rel = long_active[2];
      end
      la_prev = long_active[2];
    end
    checkOutput("long_count", 32'(long_cnt), 32'd1);
    checkOutput("long_delay", 32'(long_edge - press_edge), 32'(LONG_MS));
    checkOutput("repeat_count", 32'(rep_cnt), 32'd3);
    checkOutput("release_edge", 32'(rel_edge), 32'd50);
    checkOutput("la_before_release", 32'(la_before_rel), 32'd1);
    checkOutput("la_at_release", 32'(la_at_rel), 32'd0);

    // All four channels pressed together.
    applyReset("rst2");
    for (int i = 0; i < 30; i++) begin
      applyStimulus(4'b1111);
      if (press_pulse != '0) break;
    end
    checkOutput("simul_press", 32'(press_pulse), 32'hF);
    checkOutput("simul_edge", 32'(edge_cnt), 32'(2 + STABLE_MS));

    // Keep holding into LONG, then reset mid-hold with input still pressed.
    for (int i = 0; i < 30; i++) applyStimulus(4'b1111);
    checkOutput("la_before_reset", 32'(long_active), 32'hF);
    applyReset("midrst");
    rel_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(4'b1111);
      rel_cnt += int'(release_pulse != '0);
      if (press_pulse != '0) break;
    end
    checkOutput("post_reset_press", 32'(press_pulse), 32'hF);
    checkOutput("post_reset_edge", 32'(edge_cnt), 32'(2 + STABLE_MS));
    checkOutput("post_reset_no_release", 32'(rel_cnt), 32'd0);

    // Raw inputs high (released, active-low) from reset: nothing ever fires.
    noisy_in = '1;
    applyReset("rst3");
    act = '0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(4'b0000);
      act = act | debounced | press_pulse | release_pulse | long_pulse |
            repeat_pulse | long_active;
    end
    checkOutput("idle_high_quiet", 32'(act), 32'd0);
    press_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(4'b1000);
      press_cnt += int'(press_pulse[3]);
    end
    checkOutput("driven_low_press", 32'(press_cnt), 32'd1);

    // Randomized bursts: mixes sub-threshold glitches with long holds.
    lvl = 4'b1000;
    for (int c = 0; c < NUM_CH; c++) dur[c] = $urandom_range(1, 20);
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) applyReset("rnd_rst");
      for (int c = 0; c < NUM_CH; c++) begin
        if (dur[c] == 0) begin
          lvl[c] = ~lvl[c];
          dur[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, STABLE_MS)
                                                : $urandom_range(STABLE_MS, 70);
        end
        dur[c]--;
      end
      applyStimulus(lvl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
